clk_reset_seq: RTL

//  Parametrised board reset/status sequencer. Replaces ad-hoc lock-counter resets in synth tops.

---
 rtl/celery_pkg.sv | 22 ++
 rtl/cdc_sync_bit.sv | 32 +++
 rtl/clk_reset_seq.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/celery_pkg.sv
// -----------------------------------------------------------------------------
// celery_pkg
// Shared types and helpers for the board reset/status sequencer.
//   seq_state_e : sequencer state; the encoding is exported on the
//                 clk_reset_seq seq_state port, so do not reorder it.
//   cnt_w()     : width of a counter that runs 0..limit-1 (never below 1 bit).
// -----------------------------------------------------------------------------
package celery_pkg;

   typedef enum logic [2:0] {
      SEQ_WAIT_LOCK = 3'd0,
      SEQ_RELEASE   = 3'd1,
      SEQ_RUN       = 3'd2,
      SEQ_RETRY     = 3'd3,
      SEQ_FAULT     = 3'd4
   } seq_state_e;

   function automatic int cnt_w(input int limit);
      return (limit > 1) ? $clog2(limit) : 1;
   endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// -----------------------------------------------------------------------------
// cdc_sync_bit
// Two-flop synchroniser for a single asynchronous level into the clk domain.
// Ports:
//   clk  in  destination clock
//   rst  in  asynchronous active-high reset; both flops clear to 0
//   i_d  in  asynchronous input level
//   o_q  out synchronised level, two clk edges after i_d
// -----------------------------------------------------------------------------
module cdc_sync_bit (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/clk_reset_seq.sv
// -----------------------------------------------------------------------------
// clk_reset_seq
// Board reset/status sequencer. Debounces MMCM lock, releases NUM_STAGES
// active-low domain resets in order (stage 0 first), supervises peripheral
// init with a timeout and bounded retry, and drives a heartbeat LED.
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous active-high reset
//   locked        in   MMCM lock (asynchronous, synchronised here)
//   sw_reset_req  in   single-cycle request for a full resequence
//   init_done     in   peripheral init complete (level)
//   init_error    in   peripheral init failed (level)
//   stage_rst_n   out  per-domain active-low resets, registered
//   seq_state     out  current seq_state_e encoding
//   retry_cnt     out  retries since last rst / sw_reset_req
//   fault         out  sticky fault flag
//   heartbeat     out  status LED
// -----------------------------------------------------------------------------
module clk_reset_seq
   import celery_pkg::*;
#(
   parameter int NUM_STAGES   = 3,
   parameter int LOCK_FILTER  = 256,
   parameter int STAGE_DELAY  = 256,
   parameter int INIT_TIMEOUT = 50_000_000,
   parameter int MAX_RETRIES  = 3,
   parameter int HB_DIV_LOG2  = 25
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             locked,
   input  logic                             sw_reset_req,
   input  logic                             init_done,
   input  logic                             init_error,
   output logic [NUM_STAGES-1:0]            stage_rst_n,
   output logic [2:0]                       seq_state,
   output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt,
   output logic                             fault,
   output logic                             heartbeat
);

   localparam int FILT_W = cnt_w(LOCK_FILTER);
   localparam int DLY_W  = cnt_w(STAGE_DELAY);
   localparam int TO_W   = cnt_w(INIT_TIMEOUT);
   localparam int STG_W  = cnt_w(NUM_STAGES);
   localparam int RC_W   = $clog2(MAX_RETRIES + 1);
   localparam int HB_MSB = HB_DIV_LOG2 - 1;

   // Registered state
   seq_state_e              r_state;
   logic [FILT_W-1:0]       r_filt;
   logic [DLY_W-1:0]        r_dly;
   logic [STG_W-1:0]        r_stg;
   logic [TO_W-1:0]         r_to;
   logic [RC_W-1:0]         r_retry;
   logic                    r_fault;
   logic [NUM_STAGES-1:0]   r_rst_n;
   logic [HB_DIV_LOG2-1:0]  r_hb_cnt;
   logic                    r_heartbeat;

   // Next-state values
   seq_state_e              w_state_nxt;
   logic [FILT_W-1:0]       w_filt_nxt;
   logic [DLY_W-1:0]        w_dly_nxt;
   logic [STG_W-1:0]        w_stg_nxt;
   logic [TO_W-1:0]         w_to_nxt;
   logic [RC_W-1:0]         w_retry_nxt;
   logic                    w_fault_nxt;
   logic [NUM_STAGES-1:0]   w_rst_n_nxt;
   logic                    w_hb_nxt;

   logic                    w_locked_s;
   logic                    w_lock_lost;
   logic                    w_timeout;
   logic [RC_W-1:0]         w_retry_inc;

   cdc_sync_bit u_lock_sync (
      .clk (clk),
      .rst (rst),
      .i_d (locked),
      .o_q (w_locked_s)
   );

   // Lock loss only matters once the filter has passed; FAULT ignores it.
   assign w_lock_lost = !w_locked_s &&
                        ((r_state == SEQ_RELEASE) || (r_state == SEQ_RUN) ||
                         (r_state == SEQ_RETRY));
   assign w_timeout   = !init_done && (r_to == TO_W'(INIT_TIMEOUT - 1));
   assign w_retry_inc = r_retry + RC_W'(1);

   always_comb begin
      w_state_nxt = r_state;
      w_filt_nxt  = r_filt;
      w_dly_nxt   = r_dly;
      w_stg_nxt   = r_stg;
      w_to_nxt    = r_to;
      w_retry_nxt = r_retry;
      w_fault_nxt = r_fault;
      w_rst_n_nxt = r_rst_n;

      if (sw_reset_req) begin
         w_state_nxt = SEQ_WAIT_LOCK;
         w_filt_nxt  = '0;
         w_dly_nxt   = '0;
         w_stg_nxt   = '0;
         w_to_nxt    = '0;
         w_retry_nxt = '0;
         w_fault_nxt = 1'b0;
         w_rst_n_nxt = '0;
      end else if (w_lock_lost) begin
         // Retry count survives a lock loss; it is not a retry itself.
         w_state_nxt = SEQ_WAIT_LOCK;
         w_filt_nxt  = '0;
         w_dly_nxt   = '0;
         w_stg_nxt   = '0;
         w_to_nxt    = '0;
         w_rst_n_nxt = '0;
      end else begin
         case (r_state)
            SEQ_WAIT_LOCK: begin
               w_rst_n_nxt = '0;
               if (!w_locked_s) begin
                  w_filt_nxt = '0;
               end else if (r_filt == FILT_W'(LOCK_FILTER - 1)) begin
                  w_state_nxt = SEQ_RELEASE;
                  w_filt_nxt  = '0;
                  w_dly_nxt   = '0;
                  w_stg_nxt   = '0;
               end else begin
                  w_filt_nxt = r_filt + FILT_W'(1);
               end
            end

            SEQ_RELEASE: begin
               if (r_dly == DLY_W'(STAGE_DELAY - 1)) begin
                  // Stages are only ever set in index order, so release is monotone.
                  w_rst_n_nxt[r_stg] = 1'b1;
                  w_dly_nxt          = '0;
                  if (r_stg == STG_W'(NUM_STAGES - 1)) begin
                     w_state_nxt = SEQ_RUN;
                     w_stg_nxt   = '0;
                     w_to_nxt    = '0;
                  end else begin
                     w_stg_nxt = r_stg + STG_W'(1);
                  end
               end else begin
                  w_dly_nxt = r_dly + DLY_W'(1);
               end
            end

            SEQ_RUN: begin
               // init_error is checked first so it wins over init_done.
               if (init_error || w_timeout) begin
                  w_retry_nxt = w_retry_inc;
                  w_rst_n_nxt = '0;
                  w_dly_nxt   = '0;
                  w_to_nxt    = '0;
                  if (w_retry_inc == RC_W'(MAX_RETRIES)) begin
                     w_state_nxt = SEQ_FAULT;
                     w_fault_nxt = 1'b1;
                  end else begin
                     w_state_nxt = SEQ_RETRY;
                  end
               end else if (!init_done) begin
                  w_to_nxt = r_to + TO_W'(1);
               end
            end

            SEQ_RETRY: begin
               w_rst_n_nxt = '0;
               if (r_dly == DLY_W'(STAGE_DELAY - 1)) begin
                  w_state_nxt = SEQ_RELEASE;
                  w_dly_nxt   = '0;
                  w_stg_nxt   = '0;
               end else begin
                  w_dly_nxt = r_dly + DLY_W'(1);
               end
            end

            SEQ_FAULT: begin
               w_rst_n_nxt = '0;
               w_fault_nxt = 1'b1;
            end

            default: begin
               w_state_nxt = SEQ_WAIT_LOCK;
               w_rst_n_nxt = '0;
            end
         endcase
      end
   end

   // Heartbeat rate follows the current state: slow in RUN, 4x faster while
   // sequencing, solid on in FAULT.
   always_comb begin
      case (r_state)
         SEQ_RUN:   w_hb_nxt = r_hb_cnt[HB_MSB];
         SEQ_FAULT: w_hb_nxt = 1'b1;
         default:   w_hb_nxt = r_hb_cnt[HB_MSB-2];
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= SEQ_WAIT_LOCK;
         r_filt      <= '0;
         r_dly       <= '0;
         r_stg       <= '0;
         r_to        <= '0;
         r_retry     <= '0;
         r_fault     <= 1'b0;
         r_rst_n     <= '0;
         r_hb_cnt    <= '0;
         r_heartbeat <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_filt      <= w_filt_nxt;
         r_dly       <= w_dly_nxt;
         r_stg       <= w_stg_nxt;
         r_to        <= w_to_nxt;
         r_retry     <= w_retry_nxt;
         r_fault     <= w_fault_nxt;
         r_rst_n     <= w_rst_n_nxt;
         r_hb_cnt    <= r_hb_cnt + HB_DIV_LOG2'(1);
         r_heartbeat <= w_hb_nxt;
      end
   end

   assign stage_rst_n = r_rst_n;
   assign seq_state   = r_state;
   assign retry_cnt   = r_retry;
   assign fault       = r_fault;
   assign heartbeat   = r_heartbeat;

endmodule
